// File: rtl/dds_wave_gen_pkg.sv
// Shared types and constants for the DDS waveform generator: waveform codes, FSM states,
// the packed config record and the output saturation helper.
package dds_wave_gen_pkg;

  localparam logic [7:0] DA_MID = 8'd128;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    wave_e       wave;
    logic [31:0] freq;
    logic [9:0]  phase;
    logic [7:0]  amp;
    logic [7:0]  ofs;
    logic [7:0]  duty;
    logic [15:0] burst;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    wave:  WAVE_SINE,
    freq:  32'd0,
    phase: 10'd0,
    amp:   8'd255,
    ofs:   8'd0,
    duty:  8'd128,
    burst: 16'd0
  };

  function automatic logic [7:0] sat_u8(input logic signed [9:0] v);
    if (v < 10'sd0) return 8'd0;
    if (v > 10'sd255) return 8'd255;
    return v[7:0];
  endfunction

endpackage

// File: rtl/dds_wave_gen_if.sv
// Config write port of the DDS generator: all cfg_* land in a shadow register on cfg_valid,
// cfg_ready reports that no shadow update is still waiting to be committed.
interface dds_wave_gen_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_wave;
  logic [31:0] cfg_freq;
  logic [9:0]  cfg_phase;
  logic [7:0]  cfg_amp;
  logic [7:0]  cfg_ofs;
  logic [7:0]  cfg_duty;
  logic [15:0] cfg_burst;

  modport master (
    output cfg_valid, cfg_wave, cfg_freq, cfg_phase, cfg_amp, cfg_ofs, cfg_duty, cfg_burst,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_wave, cfg_freq, cfg_phase, cfg_amp, cfg_ofs, cfg_duty, cfg_burst,
    output cfg_ready
  );
endinterface

// File: rtl/dds_wave_gen_sine_lut_q.sv
// Registered 256x7 quarter-wave sine ROM (1-cycle latency). The table is built at elaboration
// with a Bhaskara rational approximation sampled at bin centres, rounded to 0..127.
module dds_wave_gen_sine_lut_q (
  input  logic       da_clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  output logic [6:0] q
);

  function automatic logic [1791:0] build_table();
    logic [1791:0] t;
    longint x, p, num, den;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      // x is the bin-centre angle in 1/256 degree; p = x*(180deg - x) in the same scale squared
      x   = longint'(2 * i + 1) * 45;
      p   = x * (longint'(46080) - x);
      num = p * 4 * 127;
      den = longint'(40500) * 65536 - p;
      t[i*7 +: 7] = 7'((2 * num + den) / (2 * den));
    end
    return t;
  endfunction

  localparam logic [1791:0] TABLE = build_table();

  always_ff @(posedge da_clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= TABLE[int'(addr) * 7 +: 7];
  end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator for the 8-bit DAC: phase accumulator with burst FSM, shadowed config
// committed on period boundaries, and a 4-stage waveform/gain/offset pipeline.
module dds_wave_gen
  import dds_wave_gen_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              da_clk,
  input  logic              rst_n,
  input  logic              run,
  dds_wave_gen_if.slave     cfg,
  output logic [7:0]        da_data,
  output logic              wave_sync,
  output logic              burst_done,
  output logic              busy
);

  state_e            state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    acc_sum;
  logic [15:0]       burst_cnt;
  logic              pending, period_start;
  logic              wrap, commit, last_period;
  cfg_t              shadow, act;

  always_comb begin
    acc_sum     = {1'b0, acc} + {1'b0, ACC_W'(act.freq)};
    wrap        = (state == ST_RUN) && acc_sum[ACC_W];
    commit      = pending && ((state != ST_RUN) || wrap);
    last_period = (act.burst != 16'd0) && ((burst_cnt + 16'd1) == act.burst);
  end

  assign busy          = (state == ST_RUN);
  assign cfg.cfg_ready = ~pending;

  // A write landing on the commit cycle keeps pending set, so the newer values wait for the next wrap.
  always_ff @(posedge da_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      acc          <= '0;
      burst_cnt    <= '0;
      pending      <= 1'b0;
      period_start <= 1'b0;
      burst_done   <= 1'b0;
      shadow       <= CFG_RESET;
      act          <= CFG_RESET;
    end else begin
      burst_done   <= 1'b0;
      period_start <= 1'b0;
      if (commit) act <= shadow;
      if (cfg.cfg_valid) begin
        shadow <= '{wave: wave_e'(cfg.cfg_wave), freq: cfg.cfg_freq, phase: cfg.cfg_phase,
                    amp: cfg.cfg_amp, ofs: cfg.cfg_ofs, duty: cfg.cfg_duty, burst: cfg.cfg_burst};
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          acc       <= '0;
          burst_cnt <= '0;
          if (run) begin
            state        <= ST_RUN;
            period_start <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state <= ST_IDLE;
            acc   <= '0;
          end else if (wrap && last_period) begin
            state      <= ST_HOLD;
            acc        <= '0;
            burst_cnt  <= '0;
            burst_done <= 1'b1;
          end else begin
            acc <= acc_sum[ACC_W-1:0];
            if (wrap) begin
              burst_cnt    <= burst_cnt + 16'd1;
              period_start <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          acc <= '0;
          if (!run) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic              s1_valid, s1_sync;
  logic [ADDR_W-1:0] s1_addr;
  wave_e             s1_wave;
  logic [7:0]        s1_duty, s1_amp, s1_ofs;
  logic              s2_valid, s2_sync, s2_is_sine, s2_neg;
  logic [7:0]        s2_raw, s2_amp, s2_ofs;
  logic [6:0]        s2_q;
  logic              s3_valid, s3_sync;
  logic signed [8:0] s3_m;
  logic [7:0]        s3_ofs;
  logic [7:0]        lut_idx, raw_next, raw;
  logic signed [8:0] s_val;
  logic signed [18:0] prod;
  logic signed [9:0] out_sum;

  always_comb begin
    lut_idx  = s1_addr[8] ? ~s1_addr[7:0] : s1_addr[7:0];
    raw_next = s1_addr[9:2];
    case (s1_wave)
      WAVE_SQUARE: raw_next = (s1_addr[9:2] < s1_duty) ? 8'd255 : 8'd0;
      WAVE_TRI:    raw_next = s1_addr[9] ? ~s1_addr[8:1] : s1_addr[8:1];
      default:     raw_next = s1_addr[9:2];
    endcase
    raw     = s2_is_sine ? (s2_neg ? (8'd128 - {1'b0, s2_q}) : (8'd128 + {1'b0, s2_q})) : s2_raw;
    s_val   = $signed({1'b0, raw}) - 9'sd128;
    prod    = s_val * $signed({1'b0, {1'b0, s2_amp} + 9'd1});
    out_sum = 10'(s3_m) + 10'sd128 + 10'($signed(s3_ofs));
  end

  dds_wave_gen_sine_lut_q u_sine_lut (
    .da_clk (da_clk),
    .rst_n  (rst_n),
    .addr   (lut_idx),
    .q      (s2_q)
  );

  // Every sample carries the config that was active when its phase was registered.
  always_ff @(posedge da_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_sync <= 1'b0; s1_addr <= '0; s1_wave <= WAVE_SINE;
      s1_duty <= '0; s1_amp <= '0; s1_ofs <= '0;
      s2_valid <= 1'b0; s2_sync <= 1'b0; s2_is_sine <= 1'b0; s2_neg <= 1'b0;
      s2_raw <= '0; s2_amp <= '0; s2_ofs <= '0;
      s3_valid <= 1'b0; s3_sync <= 1'b0; s3_m <= '0; s3_ofs <= '0;
      da_data <= DA_MID; wave_sync <= 1'b0;
    end else begin
      s1_valid   <= (state == ST_RUN);
      s1_sync    <= period_start;
      s1_addr    <= acc[ACC_W-1 -: ADDR_W] + act.phase;
      s1_wave    <= act.wave;
      s1_duty    <= act.duty;
      s1_amp     <= act.amp;
      s1_ofs     <= act.ofs;
      s2_valid   <= s1_valid;
      s2_sync    <= s1_sync;
      s2_is_sine <= (s1_wave == WAVE_SINE);
      s2_neg     <= s1_addr[9];
      s2_raw     <= raw_next;
      s2_amp     <= s1_amp;
      s2_ofs     <= s1_ofs;
      s3_valid   <= s2_valid;
      s3_sync    <= s2_sync;
      s3_m       <= prod[16:8];
      s3_ofs     <= s2_ofs;
      da_data    <= s3_valid ? sat_u8(out_sum) : DA_MID;
      wave_sync  <= s3_valid & s3_sync;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: a cycle reference model queues the expected DAC code
// for each registered phase and the queue is drained as samples leave the 4-stage pipeline.
module tb_dds_wave_gen;

  logic       da_clk = 1'b0;
  logic       rst_n, run;
  logic [7:0] da_data;
  logic       wave_sync, burst_done, busy;
  int         checks = 0;
  int         errors = 0;

  dds_wave_gen_if cfg_bus ();

  dds_wave_gen dut (
    .da_clk     (da_clk),
    .rst_n      (rst_n),
    .run        (run),
    .cfg        (cfg_bus),
    .da_data    (da_data),
    .wave_sync  (wave_sync),
    .burst_done (burst_done),
    .busy       (busy)
  );

  always #5 da_clk = ~da_clk;

  typedef struct {
    logic [1:0]  wave;
    logic [31:0] freq;
    logic [9:0]  phase;
    logic [7:0]  amp, ofs, duty;
    logic [15:0] burst;
  } mcfg_t;

  typedef struct {
    int code;
    bit sync;
    bit tol;
    bit live;
  } exp_t;

  exp_t        exp_q[$];
  int          m_state, m_cnt;
  logic [31:0] m_acc;
  bit          m_pending, m_pstart, m_done;
  mcfg_t       m_shadow, m_act;
  int          obs_min, obs_max, sync_cnt, sync_t1, sync_t2, done_cnt, cyc;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic mcfg_t def_cfg();
    mcfg_t c;
    c.wave = 2'd0; c.freq = 32'd0; c.phase = 10'd0; c.amp = 8'd255;
    c.ofs = 8'd0; c.duty = 8'd128; c.burst = 16'd0;
    return c;
  endfunction

  // Ideal waveform from the datapath description; sine uses real math, so it carries a tolerance.
  function automatic int model_sample(input logic [31:0] acc, input mcfg_t c, output bit tol);
    int addr, idx, q, raw, s, m, v;
    addr = (int'(acc >> 22) + int'(c.phase)) % 1024;
    tol  = 1'b0;
    case (c.wave)
      2'd0: begin
        idx = ((addr & 256) != 0) ? 255 - (addr & 255) : (addr & 255);
        q   = $rtoi(127.0 * $sin(3.141592653589793 * (real'(idx) + 0.5) / 512.0) + 0.5);
        raw = ((addr & 512) != 0) ? 128 - q : 128 + q;
        tol = 1'b1;
      end
      2'd1:    raw = ((addr >> 2) < int'(c.duty)) ? 255 : 0;
      2'd2:    raw = ((addr & 512) != 0) ? 255 - ((addr >> 1) & 255) : ((addr >> 1) & 255);
      default: raw = addr >> 2;
    endcase
    s = raw - 128;
    m = $rtoi($floor(real'(s * (int'(c.amp) + 1)) / 256.0));
    v = m + 128 + int'($signed(c.ofs));
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic model_reset();
    exp_t e;
    m_state = 0; m_cnt = 0; m_acc = '0;
    m_pending = 1'b0; m_pstart = 1'b0; m_done = 1'b0;
    m_shadow = def_cfg(); m_act = def_cfg();
    exp_q.delete();
    e.code = 128; e.sync = 1'b0; e.tol = 1'b0; e.live = 1'b0;
    repeat (4) exp_q.push_back(e);
  endtask

  task automatic model_step();
    logic [32:0] sum;
    bit          wrap, commit;
    mcfg_t       nact;
    exp_t        e;
    bit          t;
    sum    = {1'b0, m_acc} + {1'b0, m_act.freq};
    wrap   = (m_state == 1) && sum[32];
    commit = m_pending && ((m_state != 1) || wrap);
    nact   = commit ? m_shadow : m_act;
    if (cfg_bus.cfg_valid) begin
      m_shadow.wave = cfg_bus.cfg_wave;   m_shadow.freq = cfg_bus.cfg_freq;
      m_shadow.phase = cfg_bus.cfg_phase; m_shadow.amp = cfg_bus.cfg_amp;
      m_shadow.ofs = cfg_bus.cfg_ofs;     m_shadow.duty = cfg_bus.cfg_duty;
      m_shadow.burst = cfg_bus.cfg_burst;
      m_pending = 1'b1;
    end else if (commit) begin
      m_pending = 1'b0;
    end
    m_done = 1'b0; m_pstart = 1'b0;
    case (m_state)
      0: begin
        m_acc = '0; m_cnt = 0;
        if (run) begin m_state = 1; m_pstart = 1'b1; end
      end
      1: begin
        if (!run) begin
          m_state = 0; m_acc = '0;
        end else if (wrap && m_act.burst != 0 && m_cnt + 1 == int'(m_act.burst)) begin
          m_state = 2; m_acc = '0; m_done = 1'b1; m_cnt = 0;
        end else begin
          m_acc = sum[31:0];
          if (wrap) begin m_cnt++; m_pstart = 1'b1; end
        end
      end
      default: begin
        m_acc = '0;
        if (!run) m_state = 0;
      end
    endcase
    m_act = nact;
    if (m_state == 1) begin
      e.code = model_sample(m_acc, m_act, t);
      e.tol = t; e.sync = m_pstart; e.live = 1'b1;
    end else begin
      e.code = 128; e.tol = 1'b0; e.sync = 1'b0; e.live = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    int   d;
    model_step();
    @(posedge da_clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    if (e.tol) begin
      d = int'(da_data) - e.code;
      check_output("da_sine_within_1", 32'(d >= -1 && d <= 1), 32'd1);
    end else begin
      check_output("da_data", 32'(da_data), 32'(e.code));
    end
    check_output("wave_sync", 32'(wave_sync), 32'(e.sync));
    check_output("busy", 32'(busy), 32'(m_state == 1));
    check_output("burst_done", 32'(burst_done), 32'(m_done));
    check_output("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(!m_pending));
    if (e.live) begin
      if (int'(da_data) < obs_min) obs_min = int'(da_data);
      if (int'(da_data) > obs_max) obs_max = int'(da_data);
    end
    if (wave_sync) begin
      sync_cnt++;
      if (sync_cnt == 1) sync_t1 = cyc;
      if (sync_cnt == 2) sync_t2 = cyc;
    end
    if (burst_done) done_cnt++;
  endtask

  task automatic clear_stats();
    obs_min = 256; obs_max = -1; sync_cnt = 0; sync_t1 = 0; sync_t2 = 0; done_cnt = 0;
  endtask

  task automatic apply_stimulus(input logic [1:0] wave, input logic [31:0] freq, input logic [9:0] phase,
                                input logic [7:0] amp, input logic [7:0] ofs, input logic [7:0] duty,
                                input logic [15:0] burst);
    cfg_bus.cfg_wave = wave;   cfg_bus.cfg_freq = freq; cfg_bus.cfg_phase = phase;
    cfg_bus.cfg_amp = amp;     cfg_bus.cfg_ofs = ofs;   cfg_bus.cfg_duty = duty;
    cfg_bus.cfg_burst = burst; cfg_bus.cfg_valid = 1'b1;
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic sine_run_check();
    clear_stats();
    apply_stimulus(2'd0, 32'h0040_0000, 10'd0, 8'd255, 8'd0, 8'd128, 16'd0);
    tick();
    run = 1'b1;
    repeat (2100) tick();
    check_output("sine_peak", 32'(obs_max), 32'd255);
    check_output("sine_trough", 32'(obs_min), 32'd1);
    check_output("sync_period", 32'(sync_t2 - sync_t1), 32'd1024);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    cyc = 0;
    clear_stats();
    rst_n = 1'b0; run = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_wave = '0; cfg_bus.cfg_freq = '0; cfg_bus.cfg_phase = '0;
    cfg_bus.cfg_amp = '0; cfg_bus.cfg_ofs = '0; cfg_bus.cfg_duty = '0; cfg_bus.cfg_burst = '0;
    repeat (2) @(posedge da_clk);
    #1;
    check_output("rst_da_data", 32'(da_data), 32'd128);
    check_output("rst_wave_sync", 32'(wave_sync), 32'd0);
    check_output("rst_burst_done", 32'(burst_done), 32'd0);
    check_output("rst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    model_reset();
    repeat (3) tick();

    $display("[TB] sine, 1024-cycle period");
    sine_run_check();

    $display("[TB] sawtooth with gain and offset");
    run = 1'b0; repeat (6) tick();
    clear_stats();
    apply_stimulus(2'd3, 32'h0040_0000, 10'd0, 8'd127, 8'd100, 8'd128, 16'd0);
    tick(); run = 1'b1; repeat (1100) tick();
    check_output("saw_ofs_pos_min", 32'(obs_min), 32'd164);
    check_output("saw_ofs_pos_max", 32'(obs_max), 32'd255);
    run = 1'b0; repeat (6) tick();
    clear_stats();
    apply_stimulus(2'd3, 32'h0040_0000, 10'd0, 8'd127, 8'd156, 8'd128, 16'd0);
    tick(); run = 1'b1; repeat (1100) tick();
    check_output("saw_ofs_neg_min", 32'(obs_min), 32'd0);
    check_output("saw_ofs_neg_max", 32'(obs_max), 32'd91);

    $display("[TB] burst of 3 square periods");
    run = 1'b0; repeat (6) tick();
    clear_stats();
    apply_stimulus(2'd1, 32'h0100_0000, 10'd0, 8'd255, 8'd0, 8'd64, 16'd3);
    tick(); run = 1'b1; repeat (900) tick();
    check_output("burst_done_count", 32'(done_cnt), 32'd1);
    check_output("burst_sync_count", 32'(sync_cnt), 32'd3);
    run = 1'b0; repeat (3) tick();
    run = 1'b1; repeat (300) tick();

    $display("[TB] config writes mid-period and on the wrap cycle");
    run = 1'b0; repeat (6) tick();
    apply_stimulus(2'd3, 32'h0100_0000, 10'd100, 8'd255, 8'd0, 8'd128, 16'd0);
    tick(); run = 1'b1; repeat (100) tick();
    apply_stimulus(2'd3, 32'h0200_0000, 10'd100, 8'd255, 8'd0, 8'd128, 16'd0);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (m_state == 1 && (({1'b0, m_acc} + {1'b0, m_act.freq}) >= 33'h1_0000_0000)) found = 1'b1;
      else tick();
    end
    check_output("wrap_reached", 32'(found), 32'd1);
    if (found) apply_stimulus(2'd3, 32'h0400_0000, 10'd100, 8'd255, 8'd0, 8'd128, 16'd0);
    repeat (300) tick();

    $display("[TB] run dropped mid-period, commit in idle");
    repeat (20) tick();
    run = 1'b0; repeat (6) tick();
    apply_stimulus(2'd2, 32'h0080_0000, 10'd0, 8'd200, 8'd10, 8'd128, 16'd0);
    repeat (3) tick();
    run = 1'b1; repeat (600) tick();

    $display("[TB] reset mid-burst");
    run = 1'b0; repeat (6) tick();
    apply_stimulus(2'd1, 32'h0100_0000, 10'd0, 8'd255, 8'd0, 8'd128, 16'd5);
    tick(); run = 1'b1; repeat (400) tick();
    apply_stimulus(2'd1, 32'h0080_0000, 10'd0, 8'd255, 8'd0, 8'd128, 16'd5);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_output("async_da_data", 32'(da_data), 32'd128);
    check_output("async_busy", 32'(busy), 32'd0);
    check_output("async_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check_output("async_wave_sync", 32'(wave_sync), 32'd0);
    check_output("async_burst_done", 32'(burst_done), 32'd0);
    run = 1'b0;
    @(posedge da_clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (3) tick();
    sine_run_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
